// File: rtl/fetch_controller_if.sv
// Signal bundle between the fetch controller, instruction memory, the EX/MEM
// redirect source and the ID stage.
interface fetch_controller_if;
    logic        ex_mem_pc_src;
    logic [31:0] ex_mem_npc;
    logic        id_stall;
    logic        imem_ready;
    logic [31:0] imem_instr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        id_valid;
    logic [31:0] id_npc;
    logic [31:0] id_instr;

    modport master (
        input  ex_mem_pc_src,
        input  ex_mem_npc,
        input  id_stall,
        input  imem_ready,
        input  imem_instr,
        output imem_req,
        output imem_addr,
        output id_valid,
        output id_npc,
        output id_instr
    );

    modport slave (
        output ex_mem_pc_src,
        output ex_mem_npc,
        output id_stall,
        output imem_ready,
        output imem_instr,
        input  imem_req,
        input  imem_addr,
        input  id_valid,
        input  id_npc,
        input  id_instr
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: PC register, PC select/increment, IF/ID register
// and the request/ready handshake with instruction memory.
module fetch_controller #(
    parameter logic [31:0] RESET_PC          = 32'h0000_0000,
    parameter logic [31:0] PC_INC            = 32'd4,
    parameter int unsigned RESET_HOLD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_controller_if.master   bus
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    localparam logic [3:0] HOLD_INIT = 4'(RESET_HOLD_CYCLES);

    state_e      state_q,    state_d;
    logic [3:0]  hold_q,     hold_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] target_q,   target_d;
    logic        req_q,      req_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_npc_q,   id_npc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] pc_inc_s;

    assign pc_inc_s = pc_q + PC_INC;

    // Next-state and datapath selection; priority in FETCH is redirect > stall > accept > bubble.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        pc_d       = pc_q;
        target_d   = target_q;
        id_valid_d = id_valid_q;
        id_npc_d   = id_npc_q;
        id_instr_d = id_instr_q;

        case (state_q)
            ST_BOOT: begin
                if (hold_q <= 4'd1) begin
                    hold_d  = 4'd0;
                    state_d = ST_FETCH;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            ST_FETCH: begin
                if (bus.ex_mem_pc_src) begin
                    id_valid_d = 1'b0;
                    if (bus.imem_ready) begin
                        pc_d = bus.ex_mem_npc;
                    end else begin
                        // Outstanding request must complete at the old address first.
                        target_d = bus.ex_mem_npc;
                        state_d  = ST_DRAIN;
                    end
                end else if (bus.id_stall) begin
                    id_valid_d = id_valid_q;
                end else if (bus.imem_ready) begin
                    id_instr_d = bus.imem_instr;
                    id_npc_d   = pc_inc_s;
                    id_valid_d = 1'b1;
                    pc_d       = pc_inc_s;
                end else begin
                    id_valid_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                id_valid_d = 1'b0;
                if (bus.ex_mem_pc_src) begin
                    target_d = bus.ex_mem_npc;
                end else begin
                    target_d = target_q;
                end
                if (bus.imem_ready) begin
                    pc_d    = bus.ex_mem_pc_src ? bus.ex_mem_npc : target_q;
                    state_d = ST_FETCH;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d    = ST_FETCH;
                id_valid_d = 1'b0;
            end
        endcase

        req_d = (state_d != ST_BOOT);
    end

    // State, PC and IF/ID registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            hold_q     <= HOLD_INIT;
            pc_q       <= RESET_PC;
            target_q   <= 32'h0000_0000;
            req_q      <= 1'b0;
            id_valid_q <= 1'b0;
            id_npc_q   <= 32'h0000_0000;
            id_instr_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            req_q      <= req_d;
            id_valid_q <= id_valid_d;
            id_npc_q   <= id_npc_d;
            id_instr_q <= id_instr_d;
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = pc_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.id_npc    = id_npc_q;
    assign bus.id_instr  = id_instr_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: expected IF/ID contents are queued as
// stimulus is applied and popped by a monitor whenever ID consumes an instruction.
module tb_fetch_controller;

    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] instr;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    fetch_controller_if bus ();

    fetch_controller #(
        .RESET_PC         (32'h0000_0000),
        .PC_INC           (32'd4),
        .RESET_HOLD_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign bus.imem_instr = instr_of(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] npc, input logic [31:0] fetched_pc);
        exp_t e;
        e.npc   = npc;
        e.instr = instr_of(fetched_pc);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ID consumes IF/ID whenever it holds a valid word and ID is not stalling.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.id_valid === 1'b1 && bus.id_stall === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got npc %h instr %h expected none",
                             bus.id_npc, bus.id_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("id_npc", bus.id_npc, e.npc);
                    chk("id_instr", bus.id_instr, e.instr);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.ex_mem_pc_src = 1'b0;
        bus.ex_mem_npc    = 32'h0000_0000;
        bus.id_stall      = 1'b0;
        bus.imem_ready    = 1'b1;

        #2;
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0000_0000);
        chk("rst_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("rst_npc", bus.id_npc, 32'h0000_0000);
        chk("rst_instr", bus.id_instr, 32'h0000_0000);
        tick();
        tick();
        rst = 1'b0;

        // Boot hold, then sequential fetch up to 0x10
        chk("boot_req0", {31'd0, bus.imem_req}, 32'd0);
        tick();
        chk("boot_req1", {31'd0, bus.imem_req}, 32'd0);
        push_exp(32'h0000_0004, 32'h0000_0000);
        push_exp(32'h0000_0008, 32'h0000_0004);
        push_exp(32'h0000_000C, 32'h0000_0008);
        push_exp(32'h0000_0010, 32'h0000_000C);
        push_exp(32'h0000_0014, 32'h0000_0010);
        push_exp(32'h0000_0018, 32'h0000_0014);
        push_exp(32'h0000_001C, 32'h0000_0018);
        push_exp(32'h0000_0020, 32'h0000_001C);
        tick();
        chk("first_req", {31'd0, bus.imem_req}, 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0000_0000);
        chk("first_valid", {31'd0, bus.id_valid}, 32'd0);
        tick();
        chk("addr_4", bus.imem_addr, 32'h0000_0004);
        chk("first_id_valid", {31'd0, bus.id_valid}, 32'd1);
        tick();
        chk("addr_8", bus.imem_addr, 32'h0000_0008);
        tick();
        chk("addr_c", bus.imem_addr, 32'h0000_000C);
        tick();
        chk("addr_10", bus.imem_addr, 32'h0000_0010);

        // ID stall for three cycles at pc=0x10
        bus.id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr", bus.imem_addr, 32'h0000_0010);
            chk("stall_npc", bus.id_npc, 32'h0000_0010);
            chk("stall_valid", {31'd0, bus.id_valid}, 32'd1);
        end
        bus.id_stall = 1'b0;
        tick();
        chk("post_stall_addr", bus.imem_addr, 32'h0000_0014);
        tick();
        chk("addr_18", bus.imem_addr, 32'h0000_0018);
        tick();
        chk("addr_1c", bus.imem_addr, 32'h0000_001C);
        tick();
        chk("addr_20", bus.imem_addr, 32'h0000_0020);

        // Redirect while memory is waiting: drain old request, then fetch target
        bus.imem_ready    = 1'b0;
        bus.ex_mem_pc_src = 1'b1;
        bus.ex_mem_npc    = 32'h0000_0100;
        tick();
        bus.ex_mem_pc_src = 1'b0;
        chk("drain_addr0", bus.imem_addr, 32'h0000_0020);
        chk("drain_req", {31'd0, bus.imem_req}, 32'd1);
        chk("drain_valid0", {31'd0, bus.id_valid}, 32'd0);
        tick();
        chk("drain_addr1", bus.imem_addr, 32'h0000_0020);
        chk("drain_valid1", {31'd0, bus.id_valid}, 32'd0);
        bus.imem_ready = 1'b1;
        push_exp(32'h0000_0104, 32'h0000_0100);
        tick();
        chk("target_addr", bus.imem_addr, 32'h0000_0100);
        chk("target_valid", {31'd0, bus.id_valid}, 32'd0);
        tick();
        chk("addr_104", bus.imem_addr, 32'h0000_0104);
        tick();
        chk("addr_108", bus.imem_addr, 32'h0000_0108);

        // Redirect and stall together: flush wins
        bus.ex_mem_pc_src = 1'b1;
        bus.ex_mem_npc    = 32'h0000_0200;
        bus.id_stall      = 1'b1;
        tick();
        bus.ex_mem_pc_src = 1'b0;
        bus.id_stall      = 1'b0;
        chk("flush_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("flush_addr", bus.imem_addr, 32'h0000_0200);
        push_exp(32'h0000_0204, 32'h0000_0200);
        tick();
        chk("addr_204", bus.imem_addr, 32'h0000_0204);

        // PC wrap at the top of the address space
        bus.ex_mem_pc_src = 1'b1;
        bus.ex_mem_npc    = 32'hFFFF_FFFC;
        tick();
        bus.ex_mem_pc_src = 1'b0;
        chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        push_exp(32'h0000_0000, 32'hFFFF_FFFC);
        push_exp(32'h0000_0004, 32'h0000_0000);
        tick();
        chk("wrap_next_addr", bus.imem_addr, 32'h0000_0000);
        chk("wrap_npc", bus.id_npc, 32'h0000_0000);
        tick();
        chk("post_wrap_addr", bus.imem_addr, 32'h0000_0004);

        // Enter DRAIN, then assert reset asynchronously mid-cycle
        bus.imem_ready    = 1'b0;
        bus.ex_mem_pc_src = 1'b1;
        bus.ex_mem_npc    = 32'h0000_0300;
        tick();
        bus.ex_mem_pc_src = 1'b0;
        chk("drain2_addr", bus.imem_addr, 32'h0000_0004);
        chk("drain2_req", {31'd0, bus.imem_req}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_req", {31'd0, bus.imem_req}, 32'd0);
        chk("async_addr", bus.imem_addr, 32'h0000_0000);
        chk("async_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("async_npc", bus.id_npc, 32'h0000_0000);
        chk("async_instr", bus.id_instr, 32'h0000_0000);
        bus.imem_ready = 1'b1;
        tick();
        rst = 1'b0;
        chk("reboot_req0", {31'd0, bus.imem_req}, 32'd0);
        tick();
        chk("reboot_req1", {31'd0, bus.imem_req}, 32'd0);
        tick();
        chk("reboot_req2", {31'd0, bus.imem_req}, 32'd1);
        chk("reboot_addr", bus.imem_addr, 32'h0000_0000);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
